philo_waiter: RTL

- Central fork arbiter (the "waiter") for an N-seat dining-philosophers ring; the responder side of the hungry/eating protocol.
- Seats raise a level request when hungry and pulse done when they finish eating.
- The waiter grants eating permission so that no two ring-adjacent seats eat at once, with round-robin fairness.
- Used as the grant source for synchronous philosopher clients in parameterised ring models.

---
 rtl/philo_waiter_if.sv | 25 ++
 rtl/philo_waiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/philo_waiter_if.sv
// philo_waiter_if: seat-side request/done and waiter-side grant signals.
// master = seats (drive req/done), slave = waiter.
interface philo_waiter_if #(
  parameter int N  = 8,
  parameter int PW = $clog2(N)
);
  logic [N-1:0]           req;
  logic [N-1:0]           done;
  logic [N-1:0]           grant;
  logic [N-1:0]           new_grant;
  logic [$clog2(N+1)-1:0] eat_cnt;
  logic [PW-1:0]          ptr;
  logic                   proto_err;
  logic [N-1:0]           revoke;

  modport master (
    output req, done,
    input  grant, new_grant, eat_cnt, ptr, proto_err, revoke
  );

  modport slave (
    input  req, done,
    output grant, new_grant, eat_cnt, ptr, proto_err, revoke
  );
endinterface

// File: rtl/philo_waiter.sv
// philo_waiter: round-robin fork waiter for an N-seat ring.
// Optional eat timeout: define PHILO_WAITER_TIMEOUT_EN.
module philo_waiter #(
  parameter int N         = 8,
  parameter int PW        = $clog2(N),
  parameter int EAT_LIMIT = 15
) (
  input logic         clk,
  input logic         rst_n,
  philo_waiter_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  new_grant_q, new_grant_d;
  logic [CW-1:0] eat_cnt_q, eat_cnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          perr_q, perr_d;
  logic [N-1:0]  cand, keep, blocked;
  logic          found;

`ifdef PHILO_WAITER_TIMEOUT_EN
  localparam int TW = $clog2(EAT_LIMIT + 1);

  logic [TW-1:0] tmr_q [N];
  logic [TW-1:0] tmr_d [N];
  logic [N-1:0]  revoke_q, revoke_d;
  logic [N-1:0]  expire;

  assign blocked = revoke_q;

  // Timeout detection, surviving grants and timer update
  always_comb begin
    expire = '0;
    for (int i = 0; i < N; i++) begin
      expire[i] = grant_q[i] & ~bus.done[i]
                & (tmr_q[i] == TW'(EAT_LIMIT));
    end
    keep     = grant_q & ~bus.done & ~expire;
    revoke_d = expire;
    for (int i = 0; i < N; i++) begin
      if (new_grant_d[i])
        tmr_d[i] = '0;
      else if (keep[i])
        tmr_d[i] = tmr_q[i] + TW'(1);
      else
        tmr_d[i] = '0;
    end
  end

  // Per-seat eat timers and revoke pulse register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      revoke_q <= '0;
      for (int i = 0; i < N; i++) tmr_q[i] <= '0;
    end else begin
      revoke_q <= revoke_d;
      for (int i = 0; i < N; i++) tmr_q[i] <= tmr_d[i];
    end
  end

  assign bus.revoke = revoke_q;
`else
  assign blocked    = '0;
  assign bus.revoke = '0;

  // Grants persist until the seat reports done
  always_comb begin
    keep = grant_q & ~bus.done;
  end
`endif

  // Candidates: hungry, idle, both neighbours idle (registered view)
  always_comb begin
    cand = '0;
    for (int i = 0; i < N; i++) begin
      cand[i] = bus.req[i] & ~grant_q[i] & ~blocked[i]
              & ~grant_q[(i + N - 1) % N]
              & ~grant_q[(i + 1) % N];
    end
  end

  // Round-robin pick: scan ptr..N-1, then 0..ptr-1
  always_comb begin
    new_grant_d = '0;
    ptr_d       = ptr_q;
    found       = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && cand[i] && (i >= int'(ptr_q))) begin
        found          = 1'b1;
        new_grant_d[i] = 1'b1;
        ptr_d          = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && cand[i] && (i < int'(ptr_q))) begin
        found          = 1'b1;
        new_grant_d[i] = 1'b1;
        ptr_d          = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  // Next grant vector, its population and the sticky error
  always_comb begin
    grant_d   = keep | new_grant_d;
    eat_cnt_d = CW'($countones(grant_d));
    perr_d    = perr_q | (|(bus.done & ~grant_q));
  end

  // Main state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_q     <= '0;
      new_grant_q <= '0;
      eat_cnt_q   <= '0;
      ptr_q       <= '0;
      perr_q      <= 1'b0;
    end else begin
      grant_q     <= grant_d;
      new_grant_q <= new_grant_d;
      eat_cnt_q   <= eat_cnt_d;
      ptr_q       <= ptr_d;
      perr_q      <= perr_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.new_grant = new_grant_q;
  assign bus.eat_cnt   = eat_cnt_q;
  assign bus.ptr       = ptr_q;
  assign bus.proto_err = perr_q;
endmodule
